// File: rtl/mem_wb_stage.sv
// Memory + writeback back-end: M stage drives DMEM, W stage and tensor buffer share the regfile write port.
// Optional operand-bypass outputs are enabled with `define MEM_WB_FWD_EN.
module mem_wb_stage #(
  parameter int DATA_W      = 64,
  parameter int REG_ADDR_W  = 4,
  parameter int DMEM_ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic                   ex_regwrite,
  input  logic                   ex_is_ld,
  input  logic                   ex_is_st,
  input  logic                   ex_is_halt,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic [DATA_W-1:0]      ex_result,
  input  logic [DMEM_ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0]      ex_st_data,
  input  logic                   tn_done,
  input  logic [REG_ADDR_W-1:0]  tn_rd,
  input  logic [DATA_W-1:0]      tn_result,
  output logic [DMEM_ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]      dmem_wdata,
  output logic                   dmem_wena,
  input  logic [DATA_W-1:0]      dmem_rdata,
  output logic                   wb_wena,
  output logic [REG_ADDR_W-1:0]  wb_rd,
  output logic [DATA_W-1:0]      wb_wdata,
  output logic                   stall_req,
  output logic                   halted,
  output logic                   tbuf_ovf
`ifdef MEM_WB_FWD_EN
  ,
  output logic                   fwd_m_valid,
  output logic [REG_ADDR_W-1:0]  fwd_m_rd,
  output logic [DATA_W-1:0]      fwd_m_data,
  output logic                   fwd_w_valid,
  output logic [REG_ADDR_W-1:0]  fwd_w_rd,
  output logic [DATA_W-1:0]      fwd_w_data
`endif
);

  logic                   m_valid, m_regwrite, m_is_ld, m_is_st, m_is_halt;
  logic [REG_ADDR_W-1:0]  m_rd;
  logic [DATA_W-1:0]      m_result, m_st_data;
  logic [DMEM_ADDR_W-1:0] m_addr;
  logic                   w_valid, w_regwrite, w_is_ld, w_is_halt;
  logic [REG_ADDR_W-1:0]  w_rd;
  logic [DATA_W-1:0]      w_result;
  logic                   tbuf_valid;
  logic [REG_ADDR_W-1:0]  tbuf_rd;
  logic [DATA_W-1:0]      tbuf_data;
  logic                   halt_seen, halt_pend;
  logic                   ex_take, w_wr, w_halt;

  // once a halt reaches M nothing further is accepted from EX
  assign ex_take = ex_valid & ~halt_seen & ~(m_valid & m_is_halt);
  assign w_wr    = w_valid & w_regwrite;
  assign w_halt  = w_valid & w_is_halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_regwrite <= 1'b0;
      m_is_ld    <= 1'b0;
      m_is_st    <= 1'b0;
      m_is_halt  <= 1'b0;
      m_rd       <= '0;
      m_result   <= '0;
      m_addr     <= '0;
      m_st_data  <= '0;
      w_valid    <= 1'b0;
      w_regwrite <= 1'b0;
      w_is_ld    <= 1'b0;
      w_is_halt  <= 1'b0;
      w_rd       <= '0;
      w_result   <= '0;
    end else begin
      m_valid    <= ex_take;
      m_regwrite <= ex_take & ex_regwrite;
      m_is_ld    <= ex_take & ex_is_ld;
      m_is_st    <= ex_take & ex_is_st;
      m_is_halt  <= ex_take & ex_is_halt;
      m_rd       <= ex_rd;
      m_result   <= ex_result;
      m_addr     <= ex_addr;
      m_st_data  <= ex_st_data;
      w_valid    <= m_valid;
      w_regwrite <= m_regwrite & ~m_is_st;
      w_is_ld    <= m_is_ld;
      w_is_halt  <= m_is_halt;
      w_rd       <= m_rd;
      w_result   <= m_result;
    end
  end

  // tensor buffer: captures a tn_done that lost to W, drains on the first free cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbuf_valid <= 1'b0;
      tbuf_rd    <= '0;
      tbuf_data  <= '0;
      tbuf_ovf   <= 1'b0;
    end else begin
      if (tn_done && tbuf_valid)
        tbuf_ovf <= 1'b1;
      if (tbuf_valid) begin
        if (!w_wr)
          tbuf_valid <= 1'b0;
      end else if (tn_done && w_wr) begin
        tbuf_valid <= 1'b1;
        tbuf_rd    <= tn_rd;
        tbuf_data  <= tn_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_seen <= 1'b0;
      halt_pend <= 1'b0;
      halted    <= 1'b0;
    end else begin
      halt_seen <= halt_seen | (m_valid & m_is_halt);
      halt_pend <= halt_pend | w_halt;
      halted    <= halted | ((halt_pend | w_halt) & ~tbuf_valid);
    end
  end

  always_comb begin
    wb_wena  = 1'b0;
    wb_rd    = '0;
    wb_wdata = '0;
    if (!halted) begin
      if (w_wr) begin
        wb_wena  = 1'b1;
        wb_rd    = w_rd;
        wb_wdata = w_is_ld ? dmem_rdata : w_result;
      end else if (tbuf_valid) begin
        wb_wena  = 1'b1;
        wb_rd    = tbuf_rd;
        wb_wdata = tbuf_data;
      end else if (tn_done) begin
        wb_wena  = 1'b1;
        wb_rd    = tn_rd;
        wb_wdata = tn_result;
      end
    end
  end

  assign dmem_addr  = m_addr;
  assign dmem_wdata = m_st_data;
  assign dmem_wena  = m_valid & m_is_st & ~halted;
  assign stall_req  = tbuf_valid;

`ifdef MEM_WB_FWD_EN
  // load data only exists in W, so M never forwards a load
  assign fwd_m_valid = m_valid & m_regwrite & ~m_is_ld & ~m_is_st;
  assign fwd_m_rd    = fwd_m_valid ? m_rd : '0;
  assign fwd_m_data  = fwd_m_valid ? m_result : '0;
  assign fwd_w_valid = wb_wena & w_wr;
  assign fwd_w_rd    = fwd_w_valid ? wb_rd : '0;
  assign fwd_w_data  = fwd_w_valid ? wb_wdata : '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a cycle-level reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, ex_regwrite, ex_is_ld, ex_is_st, ex_is_halt;
  logic [3:0]  ex_rd;
  logic [63:0] ex_result, ex_st_data;
  logic [7:0]  ex_addr;
  logic        tn_done;
  logic [3:0]  tn_rd;
  logic [63:0] tn_result;
  logic [7:0]  dmem_addr;
  logic [63:0] dmem_wdata, dmem_rdata, wb_wdata;
  logic        dmem_wena, wb_wena, stall_req, halted, tbuf_ovf;
  logic [3:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_is_ld(ex_is_ld),
    .ex_is_st(ex_is_st), .ex_is_halt(ex_is_halt), .ex_rd(ex_rd),
    .ex_result(ex_result), .ex_addr(ex_addr), .ex_st_data(ex_st_data),
    .tn_done(tn_done), .tn_rd(tn_rd), .tn_result(tn_result),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wena(dmem_wena),
    .dmem_rdata(dmem_rdata), .wb_wena(wb_wena), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .stall_req(stall_req), .halted(halted), .tbuf_ovf(tbuf_ovf)
  );

  always #5 clk = ~clk;

  // environment DMEM: synchronous read, write on the same edge
  logic [63:0] dmem [0:255];
  always @(posedge clk) begin
    if (dmem_wena) dmem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= dmem[dmem_addr];
  end

  typedef struct {
    logic v, rw, ld, st, ht;
    logic [3:0] rd;
    logic [63:0] res;
    logic [7:0] addr;
    logic [63:0] sd;
    logic [63:0] ldv;
  } ins_t;

  typedef struct {
    logic [3:0] rd;
    logic [63:0] d;
  } tw_t;

  // reference model state
  ins_t        hist[$];
  tw_t         pend[$];
  logic [63:0] ref_mem [0:255];
  bit          m_halted, m_ovf, halt_issued, halt_w_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic v, input logic rw, input logic ld, input logic st,
                              input logic ht, input logic [3:0] rd, input logic [63:0] res,
                              input logic [7:0] addr, input logic [63:0] sd);
    ins_t i;
    i.v = v; i.rw = rw; i.ld = ld; i.st = st; i.ht = ht;
    i.rd = rd; i.res = res; i.addr = addr; i.sd = sd; i.ldv = '0;
    return i;
  endfunction

  function automatic ins_t bub();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 8'd0, 64'd0);
  endfunction

  task automatic model_clear();
    hist.delete();
    pend.delete();
    m_halted = 0; m_ovf = 0; halt_issued = 0; halt_w_seen = 0;
  endtask

  task automatic drive_idle();
    ex_valid = 0; ex_regwrite = 0; ex_is_ld = 0; ex_is_st = 0; ex_is_halt = 0;
    ex_rd = 0; ex_result = 0; ex_addr = 0; ex_st_data = 0;
    tn_done = 0; tn_rd = 0; tn_result = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dmem_wena"}, dmem_wena, 0);
    chk({tag, "_dmem_addr"}, dmem_addr, 0);
    chk({tag, "_dmem_wdata"}, dmem_wdata, 0);
    chk({tag, "_wb_wena"}, wb_wena, 0);
    chk({tag, "_wb_rd"}, wb_rd, 0);
    chk({tag, "_wb_wdata"}, wb_wdata, 0);
    chk({tag, "_stall"}, stall_req, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_ovf"}, tbuf_ovf, 0);
  endtask

  // one clock cycle: drive EX/tensor, check outputs at negedge, advance the model
  task automatic step(input ins_t e, input logic tn, input logic [3:0] trd, input logic [63:0] tval);
    ins_t mi, wi, acc;
    int n, pend_n;
    logic ewe, direct, w_wr, exp_dwe;
    logic [3:0] erd;
    logic [63:0] ewd;
    ex_valid = e.v; ex_regwrite = e.rw; ex_is_ld = e.ld; ex_is_st = e.st; ex_is_halt = e.ht;
    ex_rd = e.rd; ex_result = e.res; ex_addr = e.addr; ex_st_data = e.sd;
    tn_done = tn; tn_rd = trd; tn_result = tval;
    @(negedge clk);
    mi = bub(); wi = bub();
    n = hist.size();
    if (n >= 1) mi = hist[n-1];
    if (n >= 2) wi = hist[n-2];
    exp_dwe = mi.v & mi.st & ~m_halted;
    chk("dmem_wena", dmem_wena, exp_dwe);
    if (exp_dwe) begin
      chk("dmem_addr", dmem_addr, mi.addr);
      chk("dmem_wdata", dmem_wdata, mi.sd);
      ref_mem[mi.addr] = mi.sd;
    end
    if (mi.v && mi.ld) hist[n-1].ldv = ref_mem[mi.addr];
    pend_n = pend.size();
    w_wr = wi.v & wi.rw & ~wi.st;
    ewe = 0; erd = 0; ewd = 0; direct = 0;
    if (!m_halted) begin
      if (w_wr) begin
        ewe = 1; erd = wi.rd; ewd = wi.ld ? wi.ldv : wi.res;
      end else if (pend_n != 0) begin
        ewe = 1; erd = pend[0].rd; ewd = pend[0].d;
        void'(pend.pop_front());
      end else if (tn) begin
        ewe = 1; erd = trd; ewd = tval; direct = 1;
      end
    end
    chk("wb_wena", wb_wena, ewe);
    chk("wb_rd", wb_rd, erd);
    chk("wb_wdata", wb_wdata, ewd);
    chk("stall_req", stall_req, pend_n != 0);
    chk("halted", halted, m_halted);
    chk("tbuf_ovf", tbuf_ovf, m_ovf);
    if (tn && !direct) begin
      if (pend_n != 0) m_ovf = 1;
      else pend.push_back('{rd: trd, d: tval});
    end
    halt_w_seen = halt_w_seen | (wi.v & wi.ht);
    if (halt_w_seen && pend_n == 0) m_halted = 1;
    acc = e;
    acc.v = e.v & ~halt_issued;
    if (acc.v && e.ht) halt_issued = 1;
    hist.push_back(acc);
    if (hist.size() > 2) void'(hist.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(bub(), 1'b0, 4'd0, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 64'd0;
      ref_mem[i] = 64'd0;
    end
    drive_idle();
    model_clear();
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;

    // ALU writeback after two cycles
    step(mk(1, 1, 0, 0, 0, 4'd3, 64'h0001_0002_0003_0004, 8'd0, 64'd0), 0, 0, 0);
    idle(3);
    // store then load of the same word
    step(mk(1, 0, 0, 1, 0, 4'd0, 64'd0, 8'h10, 64'hDEAD_BEEF), 0, 0, 0);
    step(mk(1, 1, 1, 0, 0, 4'd5, 64'h1234, 8'h10, 64'd0), 0, 0, 0);
    idle(3);
    // tensor completion colliding with a W write
    step(mk(1, 1, 0, 0, 0, 4'd2, 64'hAAAA, 8'd0, 64'd0), 0, 0, 0);
    step(bub(), 0, 0, 0);
    step(bub(), 1, 4'd7, 64'h55);
    idle(3);
    // direct tensor write-through on an idle port
    step(bub(), 1, 4'd9, 64'h9999_0000_1111_2222);
    idle(2);

    for (int c = 0; c < 400; c++) begin
      ins_t e;
      int kind;
      logic tn;
      kind = $urandom_range(0, 2);
      e = mk((($urandom_range(0, 3) != 0) && (pend.size() == 0)),
             (kind == 2) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 7) != 0),
             kind == 1, kind == 2, 1'b0, 4'($urandom_range(0, 15)),
             {$urandom, $urandom}, 8'($urandom_range(0, 7)), {$urandom, $urandom});
      tn = (pend.size() == 0) && ($urandom_range(0, 6) == 0);
      step(e, tn, 4'($urandom_range(0, 15)), {$urandom, $urandom});
    end
    idle(3);

    // second tensor completion while the buffer is full
    step(mk(1, 1, 0, 0, 0, 4'd6, 64'h6666, 8'd0, 64'd0), 0, 0, 0);
    step(mk(1, 1, 0, 0, 0, 4'd8, 64'h8888, 8'd0, 64'd0), 0, 0, 0);
    step(bub(), 1, 4'd10, 64'hA0A0);
    step(bub(), 1, 4'd11, 64'hB0B0);
    idle(3);
    chk("ovf_sticky", tbuf_ovf, 1);

    // reset while a store sits in M
    step(mk(1, 0, 0, 1, 0, 4'd0, 64'd0, 8'h20, 64'hCAFE_F00D), 0, 0, 0);
    chk("st_in_m", dmem_wena, 1);
    drive_idle();
    rst_n = 0;
    #1 chk_all_zero("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    model_clear();
    @(posedge clk);
    #1 chk_all_zero("post_rst");
    idle(2);
    chk("st_discarded", dmem[8'h20], 64'd0);

    // halt with a tensor result still buffered
    step(mk(1, 1, 0, 0, 0, 4'd1, 64'h1111, 8'd0, 64'd0), 0, 0, 0);
    step(mk(1, 0, 0, 0, 1, 4'd0, 64'd0, 8'd0, 64'd0), 0, 0, 0);
    step(mk(1, 1, 0, 0, 0, 4'd4, 64'h4444, 8'd0, 64'd0), 1, 4'd12, 64'hC0C0);
    step(mk(1, 0, 0, 1, 0, 4'd0, 64'd0, 8'h30, 64'h3030), 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step(mk(1, 1, 0, i[0], 0, 4'(i), 64'(i), 8'h31, 64'h77), 0, 0, 0);
    chk("halted_final", halted, 1);
    chk("no_store_after_halt", dmem[8'h30], 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
